button_event_ctrl: RTL
======================

# button_event_ctrl

Sequencer that sits downstream of the button debouncer/edge detector. It consumes the debounced level and its one-cycle edge pulses and classifies user activity into short-press, long-press, double-click and auto-repeat events. It uses an internal millisecond tick prescaler and a press/release state machine. Its outputs are single-cycle pulses for the application logic.

## Interface
Parameters:
- TICK_DIV, 100_000, clock cycles per 1 ms tick (100 MHz clock); ≥2
- LONG_MS, 1000, hold time in ticks that qualifies a long press; 2..65535
- DCLICK_MS, 300, max release gap in ticks for a double click; 1..65535
- REPEAT_MS, 200, auto-repeat period in ticks while a long press is held; 1..65535

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  classifier enable; low forces IDLE
- debounced  in  1  debounced button level (informational, drives `held`)
- p_edge  in  1  one-cycle rising-edge pulse from debouncer
- n_edge  in  1  one-cycle falling-edge pulse from debouncer
- short_press  out  1  one-cycle pulse: single short press confirmed
- long_press  out  1  one-cycle pulse: hold reached LONG_MS
- double_click  out  1  one-cycle pulse: second press within window
- repeat_pulse  out  1  one-cycle pulse every REPEAT_MS during long hold
- held  out  1  registered copy of debounced
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Prescaler `presc` counts 0..TICK_DIV-1 and wraps. `tick` = (presc == TICK_DIV-1). `presc` clears to 0 on any cycle with p_edge or n_edge.
- Millisecond counter `ms_cnt` is 16 bit. It increments on tick and saturates at 65535. It clears to 0 on every state transition.
- `hit(N)` = tick && ms_cnt == N-1.
- States and transitions are evaluated in priority order. Any transition not listed holds the current state.
  - Any state, enable=0: go to IDLE, no pulse.
  - IDLE: p_edge → PRESS1.
  - PRESS1: n_edge → WAIT2; hit(LONG_MS) → LONG and pulse long_press.
  - WAIT2: p_edge → WAIT_REL and pulse double_click; hit(DCLICK_MS) → IDLE and pulse short_press.
  - LONG: n_edge → IDLE, no pulse; hit(REPEAT_MS) → pulse repeat_pulse, clear ms_cnt, remain in LONG.
  - WAIT_REL: n_edge → IDLE. A second press never produces long_press.
- If p_edge and n_edge are asserted in the same cycle (debouncer protocol violation), n_edge wins and p_edge is ignored.
- Spurious edges are ignored: p_edge in PRESS1/LONG/WAIT_REL, and n_edge in IDLE/WAIT2.
- A short press is only reported after the double-click window expires without a second press.
- All outputs are registered. Pulses last exactly one cycle, and at most one event pulse is asserted in any cycle.

## Timing
- Reset (asynchronous assert): state=IDLE; presc=0; ms_cnt=0; all outputs 0. Release is synchronous to clk.
- Reset asserted mid-operation drops any pending event with no pulse.
- Let k be the clk edge that samples the entering edge pulse. A hit(N) pulse then goes high at edge k+N·TICK_DIV.
  - long_press: k = p_edge edge, N = LONG_MS.
  - short_press: k = n_edge edge, N = DCLICK_MS.
- repeat_pulse fires at edges (LONG entry) + m·REPEAT_MS·TICK_DIV, for m ≥ 1.
- double_click goes high at edge k+1 after the second p_edge is sampled at edge k.
- busy rises one cycle after the p_edge that leaves IDLE, and falls one cycle after the exit condition.
- held lags debounced by 1 cycle.
- An enable drop takes effect at the next edge; no pulse is issued in that cycle.

## Test plan
Bench parameters: TICK_DIV=4, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3. Edge numbers count from the first p_edge sample = edge 0.
- **Reset:** assert reset_n=0 mid-cycle with p_edge toggling → all outputs 0 immediately. After release, busy=0 until the next p_edge.
- **Short press:** p_edge at 0, n_edge at 20 → short_press high only at edge 40; busy low from edge 41; no other pulses.
- **Long press with repeat:** p_edge at 0, hold, n_edge at 70 → long_press at edge 40, repeat_pulse at 52 and 64, busy low after 71, no short_press.
- **Double click:** p_edge at 0, n_edge at 8, p_edge at 16, n_edge at 60 → double_click at edge 17 only; no short_press or long_press; busy low after 61.
- **Late second press:** n_edge at 8, p_edge at 40 → short_press at edge 28; the new press enters PRESS1, with long_press at edge 80 if held.
- **Enable and collision:** enable=0 at edge 12 during WAIT2 → no short_press. p_edge and n_edge together in PRESS1 → treated as n_edge, state goes to WAIT2.

Source files
------------

// File: rtl/button_event_ctrl_if.sv
// Signal bundle between the button debouncer/application side and button_event_ctrl.
// master drives the debounced button inputs; slave is the classifier.
interface button_event_ctrl_if;
    logic enable;
    logic debounced;
    logic p_edge;
    logic n_edge;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_pulse;
    logic held;
    logic busy;

    modport master (
        output enable, debounced, p_edge, n_edge,
        input  short_press, long_press, double_click, repeat_pulse, held, busy
    );

    modport slave (
        input  enable, debounced, p_edge, n_edge,
        output short_press, long_press, double_click, repeat_pulse, held, busy
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Classifies debounced button activity into short-press, long-press, double-click
// and auto-repeat single-cycle pulses using a 1 ms tick prescaler and a small FSM.
module button_event_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                clk,
    input  logic                reset_n,
    button_event_ctrl_if.slave  bus
);

    localparam int unsigned     PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [15:0]     LONG_HIT   = 16'(LONG_MS - 1);
    localparam logic [15:0]     DCLICK_HIT = 16'(DCLICK_MS - 1);
    localparam logic [15:0]     REP_HIT    = 16'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        LONG,
        WAIT_REL
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     ms_q, ms_d;
    logic            dpend_q, dpend_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            dclick_q, dclick_d;
    logic            rep_q, rep_d;
    logic            held_q, held_d;
    logic            busy_q, busy_d;

    logic            tick;
    logic            press;
    logic            rel;
    logic            ms_clr;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        rel     = bus.n_edge;
        // A simultaneous rising edge is a debouncer protocol violation; the release wins.
        press   = bus.p_edge & ~bus.n_edge;

        presc_d = (bus.p_edge || bus.n_edge || tick) ? '0 : presc_q + PW'(1);

        state_d = state_q;
        ms_clr  = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        dpend_d = 1'b0;

        if (!bus.enable) begin
            state_d = IDLE;
            ms_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) state_d = PRESS1;
                end
                PRESS1: begin
                    if (rel) begin
                        state_d = WAIT2;
                    end else if (tick && ms_q == LONG_HIT) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                    end
                end
                WAIT2: begin
                    if (press) begin
                        state_d = WAIT_REL;
                        dpend_d = 1'b1;
                    end else if (tick && ms_q == DCLICK_HIT) begin
                        state_d = IDLE;
                        short_d = 1'b1;
                    end
                end
                LONG: begin
                    if (rel) begin
                        state_d = IDLE;
                    end else if (tick && ms_q == REP_HIT) begin
                        rep_d  = 1'b1;
                        ms_clr = 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (rel) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (ms_clr || state_d != state_q) begin
            ms_d = '0;
        end else if (tick && ms_q != '1) begin
            ms_d = ms_q + 16'd1;
        end else begin
            ms_d = ms_q;
        end

        // double_click is reported one cycle after the second press is accepted;
        // an enable drop in that cycle cancels it.
        dclick_d = dpend_q & bus.enable;
        busy_d   = (state_q != IDLE);
        held_d   = bus.debounced;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            dpend_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dclick_q <= 1'b0;
            rep_q    <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            dpend_q  <= dpend_d;
            short_q  <= short_d;
            long_q   <= long_d;
            dclick_q <= dclick_d;
            rep_q    <= rep_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_click = dclick_q;
    assign bus.repeat_pulse = rep_q;
    assign bus.held         = held_q;
    assign bus.busy         = busy_q;

endmodule
